// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock through a
// single WIDTH+1-bit subtractor, with a start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             divByZero_o
);

  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Done
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divByZero_q, divByZero_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] shiftedRem;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;

  // The partial remainder never exceeds WIDTH-1 bits before the shift,
  // so dropping its MSB loses nothing and the extra bit exposes the borrow.
  assign shiftedRem = {partRem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign trial      = {1'b0, shiftedRem} - {1'b0, div_q};
  assign nextRem    = trial[WIDTH] ? shiftedRem : trial[WIDTH-1:0];
  assign nextQuo    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  // Result registers load on the edge that enters Done so they are valid with done_o.
  always_comb begin
    state_d     = state_q;
    partRem_d   = partRem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divByZero_d = divByZero_q;
    unique case (state_q)
      Idle: begin
        if (start_i) begin
          quo_d = dividend_i;
          if (divisor_i != '0) begin
            partRem_d = '0;
            div_d     = divisor_i;
            cnt_d     = CntW'(WIDTH);
            zero_d    = 1'b0;
            state_d   = Run;
          end else begin
            zero_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend_i;
            divByZero_d = 1'b1;
            state_d     = Done;
          end
        end
      end
      Run: begin
        partRem_d = nextRem;
        quo_d     = nextQuo;
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quotient_d  = nextQuo;
          remainder_d = nextRem;
          divByZero_d = 1'b0;
          state_d     = Done;
        end
      end
      Done: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Idle;
      partRem_q   <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divByZero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      partRem_q   <= partRem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divByZero_q <= divByZero_d;
    end
  end

  assign busy_o      = (state_q == Run);
  assign done_o      = (state_q == Done);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign divByZero_o = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle-level arithmetic model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             divByZero_o;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  bit checkEn = 1'b0;
  bit randomPhase = 1'b0;
  int lastDone = -1;
  int doneCount = 0;

  int               runLeft = 0;
  bit               mDone = 1'b0;
  logic [WIDTH-1:0] expQ = '0;
  logic [WIDTH-1:0] expR = '0;
  logic [WIDTH-1:0] pendQ = '0;
  logic [WIDTH-1:0] pendR = '0;
  bit               expZ = 1'b0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .divByZero_o(divByZero_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
  endtask

  // Reference: a pending division resolves to a/b and a%b WIDTH cycles after acceptance.
  initial forever begin
    @(posedge clk);
    cycle++;
    if (rst) begin
      runLeft = 0;
      mDone   = 1'b0;
      expQ    = '0;
      expR    = '0;
      expZ    = 1'b0;
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (runLeft > 0) begin
      runLeft--;
      if (runLeft == 0) begin
        mDone = 1'b1;
        expQ  = pendQ;
        expR  = pendR;
        expZ  = 1'b0;
      end
    end else if (start_i) begin
      if (divisor_i == '0) begin
        mDone = 1'b1;
        expQ  = '1;
        expR  = dividend_i;
        expZ  = 1'b1;
      end else begin
        runLeft = WIDTH;
        pendQ   = dividend_i / divisor_i;
        pendR   = dividend_i % divisor_i;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (checkEn) begin
      checkOutput("busy", busy_o, runLeft > 0);
      checkOutput("done", done_o, mDone);
      checkOutput("quotient", quotient_o, expQ);
      checkOutput("remainder", remainder_o, expR);
      checkOutput("divByZero", divByZero_o, expZ);
      if (done_o === 1'b1 && randomPhase) begin
        doneCount++;
        if (lastDone >= 0) checkOutput("doneSpacing", cycle - lastDone, 10);
        lastDone = cycle;
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int startK, output int k);
    k = startK;
    while (done_o !== 1'b1 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int eq, input int er, input int ez, input int elat);
    int k;
    applyStimulus(a, b);
    waitDone(1, k);
    checkOutput("latency", k, elat);
    checkOutput("litQuotient", quotient_o, eq);
    checkOutput("litRemainder", remainder_o, er);
    checkOutput("litDivByZero", divByZero_o, ez);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int seen;
    rst        = 1'b1;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    @(posedge clk);
    checkEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", busy_o, 0);
    checkOutput("resetDone", done_o, 0);
    checkOutput("resetQuotient", quotient_o, 0);
    checkOutput("resetRemainder", remainder_o, 0);
    checkOutput("resetDivByZero", divByZero_o, 0);
    rst = 1'b0;

    runOp(8'd100, 8'd7, 14, 2, 0, 9);
    runOp(8'd255, 8'd1, 255, 0, 0, 9);
    runOp(8'd5, 8'd9, 0, 5, 0, 9);
    runOp(8'd255, 8'd255, 1, 0, 0, 9);
    runOp(8'd0, 8'd3, 0, 0, 0, 9);
    runOp(8'd42, 8'd0, 255, 42, 1, 1);
    runOp(8'd9, 8'd2, 4, 1, 0, 9);

    applyStimulus(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    start_i    = 1'b1;
    dividend_i = 8'd10;
    divisor_i  = 8'd5;
    @(negedge clk);
    start_i = 1'b0;
    waitDone(5, k);
    checkOutput("ignoredStartLatency", k, 9);
    checkOutput("ignoredStartQuotient", quotient_o, 66);
    checkOutput("ignoredStartRemainder", remainder_o, 2);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checkOutput("holdQuotient", quotient_o, 66);
    checkOutput("holdRemainder", remainder_o, 2);

    applyStimulus(8'd77, 8'd4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      if (done_o === 1'b1) seen++;
      @(negedge clk);
    end
    checkOutput("abortNoDone", seen, 0);
    checkOutput("abortQuotient", quotient_o, 0);
    checkOutput("abortRemainder", remainder_o, 0);
    checkOutput("abortBusy", busy_o, 0);
    runOp(8'd77, 8'd4, 19, 1, 0, 9);

    randomPhase = 1'b1;
    lastDone    = -1;
    doneCount   = 0;
    for (int c = 0; c < 11000 && doneCount < 1000; c++) begin
      @(negedge clk);
      start_i    = 1'b1;
      dividend_i = WIDTH'($urandom_range(0, 255));
      divisor_i  = WIDTH'($urandom_range(1, 255));
    end
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("randomOpsCompleted", doneCount >= 1000, 1);
    repeat (12) @(negedge clk);
    randomPhase = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
